// File: rtl/mem_access_unit.sv
// Load/store unit: runs one req/ack data-memory transaction per request.
// Builds byte enables and lane-replicated write data, and extends load data.
`ifndef ALU_LB
`define ALU_LB  6'd18
`define ALU_LH  6'd19
`define ALU_LW  6'd20
`define ALU_LBU 6'd21
`define ALU_LHU 6'd22
`define ALU_SB  6'd23
`define ALU_SH  6'd24
`define ALU_SW  6'd25
`endif

module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  alucode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW =
    (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT_CYCLES);
  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  state_t        state_q;
  logic [1:0]    sz_q;
  logic          uns_q;
  logic          st_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt_q;

  logic          busy_q;
  logic          done_q;
  logic [31:0]   load_data_q;
  logic          misal_q;
  logic          berr_q;
  logic          req_q;
  logic          we_q;
  logic [31:0]   maddr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;

  // Size code: 0 = byte, 1 = half, 2 = word.
  logic          dec_mem;
  logic          dec_st;
  logic          dec_uns;
  logic [1:0]    dec_sz;
  logic          dec_mis;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;

  always_comb begin
    dec_mem = 1'b1;
    dec_st  = 1'b0;
    dec_uns = 1'b0;
    dec_sz  = 2'd2;
    unique case (alucode)
      `ALU_LB:  dec_sz = 2'd0;
      `ALU_LH:  dec_sz = 2'd1;
      `ALU_LW:  dec_sz = 2'd2;
      `ALU_LBU: begin
        dec_sz  = 2'd0;
        dec_uns = 1'b1;
      end
      `ALU_LHU: begin
        dec_sz  = 2'd1;
        dec_uns = 1'b1;
      end
      `ALU_SB: begin
        dec_sz = 2'd0;
        dec_st = 1'b1;
      end
      `ALU_SH: begin
        dec_sz = 2'd1;
        dec_st = 1'b1;
      end
      `ALU_SW: begin
        dec_sz = 2'd2;
        dec_st = 1'b1;
      end
      default: dec_mem = 1'b0;
    endcase
  end

  always_comb begin
    dec_mis = 1'b0;
    if (dec_mem) begin
      if (dec_sz == 2'd1) dec_mis = addr[0];
      if (dec_sz == 2'd2) dec_mis = (addr[1:0] != 2'b00);
    end
  end

  always_comb begin
    unique case (dec_sz)
      2'd0: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      2'd1: begin
        be_d    = 4'b0011 << addr[1:0];
        wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data;
      end
    endcase
  end

  // Lane extraction of the returned word for the latched size/offset.
  logic [31:0] lane_w;
  logic [15:0] half_w;
  logic [31:0] ext_d;

  always_comb begin
    lane_w = mem_rdata >> {off_q, 3'b000};
    half_w = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (sz_q)
      2'd0: begin
        if (uns_q) ext_d = {24'b0, lane_w[7:0]};
        else       ext_d = {{24{lane_w[7]}}, lane_w[7:0]};
      end
      2'd1: begin
        if (uns_q) ext_d = {16'b0, half_w};
        else       ext_d = {{16{half_w[15]}}, half_w};
      end
      default: ext_d = mem_rdata;
    endcase
    if (st_q) ext_d = '0;
  end

  // Counter saturates so a disabled timeout never wraps.
  logic [CW-1:0] cnt_d;
  logic          to_hit;

  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    to_hit = TO_EN && (cnt_d == TO_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sz_q        <= '0;
      uns_q       <= 1'b0;
      st_q        <= 1'b0;
      off_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_data_q <= '0;
      misal_q     <= 1'b0;
      berr_q      <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      maddr_q     <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      misal_q <= 1'b0;
      berr_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            sz_q  <= dec_sz;
            uns_q <= dec_uns;
            st_q  <= dec_st;
            off_q <= addr[1:0];
            if (!dec_mem || dec_mis) begin
              done_q      <= 1'b1;
              misal_q     <= dec_mis;
              load_data_q <= '0;
            end else begin
              state_q <= S_REQ;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
              we_q    <= dec_st;
              maddr_q <= {addr[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
            end
          end
        end
        S_REQ: begin
          if (mem_ack || to_hit) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b1;
            berr_q      <= !mem_ack;
            load_data_q <= mem_ack ? ext_d : '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign load_data  = load_data_q;
  assign misaligned = misal_q;
  assign bus_err    = berr_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = maddr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases then random ops
// checked against an arithmetic model of the load/store rules.
`ifndef ALU_LB
`define ALU_LB  6'd18
`define ALU_LH  6'd19
`define ALU_LW  6'd20
`define ALU_LBU 6'd21
`define ALU_LHU 6'd22
`define ALU_SB  6'd23
`define ALU_SH  6'd24
`define ALU_SW  6'd25
`endif

module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  alucode = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, misaligned, bus_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .alucode(alucode), .addr(addr),
    .store_data(store_data),
    .busy(busy), .done(done),
    .load_data(load_data),
    .misaligned(misaligned), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Access width in bytes, 0 for a non-memory code.
  function automatic int size_of(input logic [5:0] c);
    case (c)
      `ALU_LB, `ALU_LBU, `ALU_SB: return 1;
      `ALU_LH, `ALU_LHU, `ALU_SH: return 2;
      `ALU_LW, `ALU_SW:           return 4;
      default:                    return 0;
    endcase
  endfunction

  function automatic bit is_store(input logic [5:0] c);
    return c == `ALU_SB || c == `ALU_SH || c == `ALU_SW;
  endfunction

  function automatic bit is_uns(input logic [5:0] c);
    return c == `ALU_LBU || c == `ALU_LHU;
  endfunction

  function automatic logic [31:0] model_load(
    input logic [5:0] c, input logic [1:0] off,
    input logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = size_of(c);
    if (n == 4) return rd;
    v = (rd >> (8 * off)) & ((32'd1 << (8 * n)) - 1);
    if (!is_uns(c) && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(
    input logic [5:0] c, input logic [31:0] sd);
    int n;
    n = size_of(c);
    if (n == 1) return sd[7:0] * 32'h0101_0101;
    if (n == 2) return sd[15:0] * 32'h0001_0001;
    return sd;
  endfunction

  // Issues one op; d = REQ cycles before ack (d >= TO: no ack).
  task automatic run_op(input logic [5:0] c,
                        input logic [31:0] a,
                        input logic [31:0] sd,
                        input int d,
                        input logic [31:0] rd,
                        input bit poke);
    int n;
    bit st;
    bit acked;
    logic [3:0] be;
    n = size_of(c);
    st = is_store(c);
    acked = 1'b0;
    be = 4'(((1 << n) - 1) << (8'(a[1:0])));
    alucode = c;
    addr = a;
    store_data = sd;
    start = 1'b1;
    @(posedge clk); #1;
    start = poke;
    addr = $urandom;
    store_data = $urandom;
    if (n == 0 || (a[1:0] % n) != 0) begin
      chk("fast_done", 32'(done), 1);
      chk("fast_misal", 32'(misaligned), 32'(n != 0));
      chk("fast_berr", 32'(bus_err), 0);
      chk("fast_busy", 32'(busy), 0);
      chk("fast_req", 32'(mem_req), 0);
      chk("fast_ld", load_data, 0);
      start = 1'b0;
      return;
    end
    for (int k = 0; k < TO; k++) begin
      chk("req", 32'(mem_req), 1);
      chk("busy", 32'(busy), 1);
      chk("maddr", mem_addr, {a[31:2], 2'b00});
      chk("be", 32'(mem_be), 32'(be));
      chk("we", 32'(mem_we), 32'(st));
      if (st) chk("wdata", mem_wdata, model_wdata(c, sd));
      chk("no_done", 32'(done), 0);
      mem_rdata = $urandom;
      if (k == d) begin
        mem_ack = 1'b1;
        mem_rdata = rd;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (k == d) begin
        acked = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("done", 32'(done), 1);
    chk("end_req", 32'(mem_req), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_misal", 32'(misaligned), 0);
    chk("berr", 32'(bus_err), 32'(!acked));
    chk("ld", load_data,
        (acked && !st) ? model_load(c, a[1:0], rd) : 32'd0);
  endtask

  logic [5:0] codes [10] = '{
    `ALU_LB, `ALU_LH, `ALU_LW, `ALU_LBU, `ALU_LHU,
    `ALU_SB, `ALU_SH, `ALU_SW, 6'd0, 6'd63
  };

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ld", load_data, 0);
    chk("rst_misal", 32'(misaligned), 0);
    chk("rst_berr", 32'(bus_err), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_wdata", mem_wdata, 0);

    run_op(`ALU_LB, 32'h1003, 0, 0, 32'h80FF_1234, 0);
    chk("lb_val", load_data, 32'hFFFF_FF80);
    run_op(`ALU_LHU, 32'h2002, 0, 3, 32'hBEEF_0000, 0);
    chk("lhu_val", load_data, 32'h0000_BEEF);
    @(posedge clk); #1;
    chk("ld_held", load_data, 32'h0000_BEEF);
    chk("idle_done", 32'(done), 0);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("stray_ack_done", 32'(done), 0);
    chk("stray_ack_ld", load_data, 32'h0000_BEEF);

    run_op(`ALU_SH, 32'h3002, 32'h1234_ABCD, 1, 0, 0);
    run_op(`ALU_SW, 32'h4001, 32'h5555_AAAA, 0, 0, 0);
    run_op(`ALU_LH, 32'h4001, 0, 0, 0, 0);
    run_op(6'd0, 32'h4000, 0, 0, 0, 0);
    run_op(`ALU_LW, 32'h4004, 0, TO, 0, 0);
    run_op(`ALU_LW, 32'h4008, 0, 1, 32'hCAFE_F00D, 0);
    chk("lw_val", load_data, 32'hCAFE_F00D);

    alucode = `ALU_LW;
    addr = 32'h5000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_rst_req", 32'(mem_req), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_req", 32'(mem_req), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    @(posedge clk); #1;
    chk("post_rst_done", 32'(done), 0);

    run_op(`ALU_LW, 32'h6000, 0, 2, 32'h0BAD_CAFE, 1);
    @(posedge clk); #1;
    chk("poke_one_done", 32'(done), 0);
    chk("poke_no_req", 32'(mem_req), 0);

    for (int i = 0; i < 120; i++) begin
      run_op(codes[$urandom_range(0, 9)], $urandom,
             $urandom, $urandom_range(0, TO + 1),
             $urandom, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
